// File: rtl/postprocess_zf_pkg.sv
// Shared ZF chain definitions: FSM encodings, slicer threshold, Gray labels
// and small fp16 helpers.
package postprocess_zf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_SLICE = 2'd2,
    ST_READY = 2'd3
  } state_t;

  // |x| < 2.0 in fp16 magnitude bits
  localparam logic [14:0] SLICE_THR = 15'h4000;

  localparam logic [1:0] GRAY_P3 = 2'b00;
  localparam logic [1:0] GRAY_P1 = 2'b01;
  localparam logic [1:0] GRAY_M1 = 2'b11;
  localparam logic [1:0] GRAY_M3 = 2'b10;

  function automatic logic [15:0] fp16_neg(input logic [15:0] x);
    return {~x[15], x[14:0]};
  endfunction

endpackage

// File: rtl/mul.sv
// Shared combinational fp16 multiplier: round-to-nearest-even, subnormals
// flushed to signed zero, overflow to infinity, canonical quiet NaN.
module mul (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] p
);
  logic              sign;
  logic [4:0]        ea, eb;
  logic [9:0]        fa, fb;
  logic [21:0]       prod;
  logic [9:0]        frac;
  logic              guard, sticky, rnd;
  logic signed [6:0] e;
  logic [14:0]       rounded;
  logic              a_inf, b_inf, a_nan, b_nan, a_zero, b_zero;

  always_comb begin
    sign   = a[15] ^ b[15];
    ea     = a[14:10];
    eb     = b[14:10];
    fa     = a[9:0];
    fb     = b[9:0];
    a_inf  = (ea == 5'h1f) && (fa == 10'd0);
    b_inf  = (eb == 5'h1f) && (fb == 10'd0);
    a_nan  = (ea == 5'h1f) && (fa != 10'd0);
    b_nan  = (eb == 5'h1f) && (fb != 10'd0);
    a_zero = (ea == 5'd0);
    b_zero = (eb == 5'd0);
    prod   = 22'({1'b1, fa}) * 22'({1'b1, fb});
    e      = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 7'sd15
             + $signed({6'b000000, prod[21]});
    // Product of two [1,2) mantissas lies in [1,4): normalise on bit 21
    if (prod[21]) begin
      frac   = prod[20:11];
      guard  = prod[10];
      sticky = |prod[9:0];
    end else begin
      frac   = prod[19:10];
      guard  = prod[9];
      sticky = |prod[8:0];
    end
    rnd     = guard & (sticky | frac[0]);
    rounded = {e[4:0], frac} + 15'(rnd);

    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      p = 16'h7e00;
    else if (a_inf || b_inf)
      p = {sign, 15'h7c00};
    else if (a_zero || b_zero)
      p = {sign, 15'h0000};
    else if (e >= 7'sd31)
      p = {sign, 15'h7c00};
    else if (e <= 7'sd0)
      p = {sign, 15'h0000};
    else
      p = {sign, rounded};
  end
endmodule

// File: rtl/postprocess_zf_controller.sv
// Handshake FSM: IDLE -> MUL -> SLICE -> READY, with datapath load strobes.
module postprocess_zf_controller
  import postprocess_zf_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic accept_in,
  output logic accept_out,
  output logic ready_out,
  output logic cap_en,
  output logic mul_en,
  output logic slice_en
);
  state_t state_reg, state_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (enable) state_next = ST_MUL;
      ST_MUL:   state_next = ST_SLICE;
      ST_SLICE: state_next = ST_READY;
      ST_READY: if (accept_in) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  assign accept_out = (state_reg == ST_IDLE);
  assign ready_out  = (state_reg == ST_READY);
  assign cap_en     = accept_out & enable;
  assign mul_en     = (state_reg == ST_MUL);
  assign slice_en   = (state_reg == ST_SLICE);
endmodule

// File: rtl/postprocess_zf_datapath.sv
// Operand capture, two fp16 multiplies by R_inv, slicing and result registers.
module postprocess_zf_datapath
  import postprocess_zf_pkg::*;
#(
  parameter bit QAM16 = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cap_en,
  input  logic        mul_en,
  input  logic        slice_en,
  input  logic [31:0] x_mid_pre,
  input  logic [15:0] r_inv,
  output logic [31:0] x_out,
  output logic [3:0]  sym_out
);
  logic [31:0] op_x;
  logic [15:0] op_r;
  logic [15:0] prod_re, prod_im;
  logic        s_re, s_im;
  logic [1:0]  code_re, code_im;
  logic [3:0]  sym_sel;

  mul u_mul_re (.a(op_x[31:16]), .b(op_r), .p(prod_re));
  mul u_mul_im (.a(op_x[15:0]),  .b(op_r), .p(prod_im));

  zf_slicer u_slice_re (.x(x_out[31:16]), .sign(s_re), .code(code_re));
  zf_slicer u_slice_im (.x(x_out[15:0]),  .sign(s_im), .code(code_im));

  assign sym_sel = QAM16 ? {code_re, code_im} : {2'b00, s_re, s_im};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_x    <= '0;
      op_r    <= '0;
      x_out   <= '0;
      sym_out <= '0;
    end else begin
      if (cap_en) begin
        op_x <= x_mid_pre;
        op_r <= r_inv;
      end
      if (mul_en)   x_out   <= {prod_re, prod_im};
      if (slice_en) sym_out <= sym_sel;
    end
  end
endmodule

// File: rtl/zf_slicer.sv
// Per-component hard slicer on raw fp16 bits: sign plus inner/outer decision.
module zf_slicer
  import postprocess_zf_pkg::*;
(
  input  logic [15:0] x,
  output logic        sign,
  output logic [1:0]  code
);
  logic inner;

  assign sign  = x[15];
  assign inner = (x[14:0] < SLICE_THR);

  always_comb begin
    case ({sign, inner})
      2'b00:   code = GRAY_P3;
      2'b01:   code = GRAY_P1;
      2'b11:   code = GRAY_M1;
      default: code = GRAY_M3;
    endcase
  end
endmodule

// File: rtl/postprocess_zf.sv
// Final ZF stage: scale reduced row value by 1/R_ii and hard-slice to a label.
module postprocess_zf
  import postprocess_zf_pkg::*;
#(
  parameter bit QAM16 = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        accept_in,
  output logic        accept_out,
  output logic        ready_out,
  input  logic [31:0] X_mid_pre,
  input  logic [15:0] R_inv,
  output logic [31:0] X_out,
  output logic [3:0]  sym_out
);
  logic cap_en, mul_en, slice_en;

  postprocess_zf_controller u_ctrl (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .accept_in  (accept_in),
    .accept_out (accept_out),
    .ready_out  (ready_out),
    .cap_en     (cap_en),
    .mul_en     (mul_en),
    .slice_en   (slice_en)
  );

  postprocess_zf_datapath #(.QAM16(QAM16)) u_dp (
    .clk       (clk),
    .reset_n   (reset_n),
    .cap_en    (cap_en),
    .mul_en    (mul_en),
    .slice_en  (slice_en),
    .x_mid_pre (X_mid_pre),
    .r_inv     (R_inv),
    .x_out     (X_out),
    .sym_out   (sym_out)
  );
endmodule
